// File: rtl/gemv_weight_streamer.sv
// GEMV weight-tile transmitter: reads a row-major weight matrix one tile-wide word at a
// time and hands each tile, with lanes past the last column zeroed, to the GEMV consumer.

module gemv_weight_streamer_chk (
  input logic        clk,
  input logic        reset_n,
  input logic        mem_req,
  input logic        mem_rvalid,
  input logic        w_valid,
  input logic        done,
  input logic [9:0]  rows,
  input logic [10:0] tpr
);
  logic        outstanding_r;
  logic        w_valid_d_r;
  logic [20:0] pulses_r;

  // Tracks the read in flight, the previous strobe and the strobes of the current stream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding_r <= 1'b0;
      w_valid_d_r   <= 1'b0;
      pulses_r      <= 21'd0;
    end else begin
      if (mem_req) begin
        outstanding_r <= 1'b1;
      end else if (mem_rvalid) begin
        outstanding_r <= 1'b0;
      end
      w_valid_d_r <= w_valid;
      if (done) begin
        pulses_r <= 21'd0;
      end else if (w_valid) begin
        pulses_r <= pulses_r + 21'd1;
      end
    end
  end

  a_one_outstanding: assert property (@(posedge clk) disable iff (!reset_n)
    !(mem_req && outstanding_r));
  a_no_back_to_back: assert property (@(posedge clk) disable iff (!reset_n)
    !(w_valid && w_valid_d_r));
  a_pulse_count: assert property (@(posedge clk) disable iff (!reset_n)
    done |-> (pulses_r == (21'(rows) * 21'(tpr))));
endmodule

module gemv_weight_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int TILE_SIZE  = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              start,
  input  logic [ADDR_WIDTH-1:0]             base_addr,
  input  logic [9:0]                        rows,
  input  logic [9:0]                        cols,
  output logic                              busy,
  output logic                              done,
  output logic                              mem_req,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  input  logic                              mem_rvalid,
  input  logic [TILE_SIZE*DATA_WIDTH-1:0]   mem_rdata,
  input  logic                              w_ready,
  output logic                              w_valid,
  output logic signed [DATA_WIDTH-1:0]      w_tile_row_out [0:TILE_SIZE-1]
);
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_WAIT_MEM = 3'd2,
    ST_PRESENT  = 3'd3,
    ST_REARM    = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  state_t                state_r, state_s;
  logic [ADDR_WIDTH-1:0] word_r, word_s;
  logic [ADDR_WIDTH-1:0] mem_addr_r, mem_addr_s;
  logic [9:0]            rows_r, rows_s, cols_r, cols_s, row_r, row_s;
  logic [10:0]           tpr_r, tpr_s, tile_r, tile_s, col_base_r, col_base_s;
  logic                  busy_r, busy_s, done_r, done_s;
  logic                  mem_req_r, mem_req_s, w_valid_r, w_valid_s;
  logic                  load_tile_s, last_tile_s;
  logic [TILE_SIZE-1:0]  lane_keep_s;
  logic signed [DATA_WIDTH-1:0] tile_data_r [0:TILE_SIZE-1];

  assign busy           = busy_r;
  assign done           = done_r;
  assign mem_req        = mem_req_r;
  assign mem_addr       = mem_addr_r;
  assign w_valid        = w_valid_r;
  assign w_tile_row_out = tile_data_r;

  assign last_tile_s = (tile_r == (tpr_r - 11'd1)) && (row_r == (rows_r - 10'd1));

  // Lane i of the current tile holds column col_base + i; anything at or past cols is padding.
  always_comb begin
    lane_keep_s = {TILE_SIZE{1'b0}};
    for (int i = 0; i < TILE_SIZE; i++) begin
      lane_keep_s[i] = (32'(col_base_r) + 32'(i)) < 32'(cols_r);
    end
  end

  // Next-state and next-output logic for the fetch/present/rearm sequence.
  always_comb begin
    state_s     = state_r;
    word_s      = word_r;
    mem_addr_s  = mem_addr_r;
    rows_s      = rows_r;
    cols_s      = cols_r;
    tpr_s       = tpr_r;
    row_s       = row_r;
    tile_s      = tile_r;
    col_base_s  = col_base_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    mem_req_s   = 1'b0;
    w_valid_s   = 1'b0;
    load_tile_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // done_r high means this is the cycle right after DONE; start is not taken here.
        if (start && !done_r) begin
          word_s     = base_addr;
          rows_s     = rows;
          cols_s     = cols;
          tpr_s      = 11'((12'(cols) + 12'(TILE_SIZE - 1)) / 12'(TILE_SIZE));
          row_s      = 10'd0;
          tile_s     = 11'd0;
          col_base_s = 11'd0;
          busy_s     = 1'b1;
          if ((rows == 10'd0) || (cols == 10'd0)) begin
            state_s = ST_DONE;
          end else begin
            state_s    = ST_FETCH;
            mem_req_s  = 1'b1;
            mem_addr_s = base_addr;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_s = ST_WAIT_MEM;
      end
      ST_WAIT_MEM: begin
        if (mem_rvalid) begin
          load_tile_s = 1'b1;
          state_s     = ST_PRESENT;
        end else begin
          state_s = ST_WAIT_MEM;
        end
      end
      ST_PRESENT: begin
        if (w_ready) begin
          w_valid_s = 1'b1;
          state_s   = ST_REARM;
        end else begin
          state_s = ST_PRESENT;
        end
      end
      ST_REARM: begin
        // The consumer's ready lags its capture, so wait for it to drop before moving on.
        if (!w_ready) begin
          word_s = word_r + ADDR_WIDTH'(1);
          if (tile_r == (tpr_r - 11'd1)) begin
            tile_s     = 11'd0;
            row_s      = row_r + 10'd1;
            col_base_s = 11'd0;
          end else begin
            tile_s     = tile_r + 11'd1;
            col_base_s = col_base_r + 11'(TILE_SIZE);
          end
          if (last_tile_s) begin
            state_s = ST_DONE;
          end else begin
            state_s    = ST_FETCH;
            mem_req_s  = 1'b1;
            mem_addr_s = word_s;
          end
        end else begin
          state_s = ST_REARM;
        end
      end
      ST_DONE: begin
        done_s  = 1'b1;
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      word_r     <= {ADDR_WIDTH{1'b0}};
      mem_addr_r <= {ADDR_WIDTH{1'b0}};
      rows_r     <= 10'd0;
      cols_r     <= 10'd0;
      tpr_r      <= 11'd0;
      row_r      <= 10'd0;
      tile_r     <= 11'd0;
      col_base_r <= 11'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      mem_req_r  <= 1'b0;
      w_valid_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      word_r     <= word_s;
      mem_addr_r <= mem_addr_s;
      rows_r     <= rows_s;
      cols_r     <= cols_s;
      tpr_r      <= tpr_s;
      row_r      <= row_s;
      tile_r     <= tile_s;
      col_base_r <= col_base_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      mem_req_r  <= mem_req_s;
      w_valid_r  <= w_valid_s;
    end
  end

  // Tile register: captured once per read and held until the next read returns.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TILE_SIZE; i++) begin
        tile_data_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (load_tile_s) begin
      for (int i = 0; i < TILE_SIZE; i++) begin
        tile_data_r[i] <= lane_keep_s[i] ? mem_rdata[i*DATA_WIDTH +: DATA_WIDTH]
                                         : {DATA_WIDTH{1'b0}};
      end
    end
  end

  gemv_weight_streamer_chk u_chk (
    .clk        (clk),
    .reset_n    (reset_n),
    .mem_req    (mem_req_r),
    .mem_rvalid (mem_rvalid),
    .w_valid    (w_valid_r),
    .done       (done_r),
    .rows       (rows_r),
    .tpr        (tpr_r)
  );
endmodule
